// File: rtl/pa_stream_pkg.sv
// Shared types and constants for the PA secret-key streamer.
package pa_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int          REGION_WORDS = 16384;
    localparam int          KEY_WORD_W   = 64;
    // Reflected form of the IEEE 802.3 polynomial 0x04C11DB7.
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;

endpackage

// File: rtl/pa_stream_fifo.sv
// Skid FIFO between the key BRAM read pipeline and the AXI-Stream output.
// Pointers and occupancy are reset; the storage array is not.
module pa_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/pa_key_streamer.sv
// Streams the secret key out of BRAM as 64-bit AXI-Stream beats after PA finishes.
// Optional CRC32 trailer beat when PA_KEY_CRC_EN is defined.
module pa_key_streamer
    import pa_stream_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] secretkey_length,
    input  logic        key_addr_index,
    output logic [14:0] bram_addra,
    output logic        bram_ena,
    input  logic [63:0] bram_douta,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   len_q;
    logic          region_q;
    logic [14:0]   words_q;
    logic [5:0]    rem_q;
    logic [14:0]   n_q;
    logic [CW-1:0] inflight_q;
    logic          last_sent_q;

    logic [26:0]   words_full;
    logic          len_bad;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          last_issue;
    logic          final_hs;

    logic          vld_p0, vld_p1;
    logic          last_p0, last_p1;
    logic          push_vld, push_last;

    logic [KEY_WORD_W:0] fifo_din, fifo_head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty, fifo_pop;

    function automatic logic [KEY_WORD_W-1:0] tail_mask(input logic [5:0] rem);
        if (rem == 6'd0) return '1;
        return ~({KEY_WORD_W{1'b1}} >> rem);
    endfunction

    assign words_full  = {1'b0, len_q[31:6]} + {26'd0, |len_q[5:0]};
    assign len_bad     = (len_q == 32'd0) || (words_full > 27'(REGION_WORDS));
    assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);
    assign issue       = (state_q == ST_READ) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign last_issue  = issue && (n_q == words_q - 15'd1);

    assign bram_ena    = issue;
    assign bram_addra  = issue ? {region_q, n_q[13:0]} : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            inflight_q  <= '0;
            last_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_q + CW'(issue) - CW'(push_vld);
            if (state_q == ST_CHECK) begin
                n_q         <= '0;
                last_sent_q <= 1'b0;
            end else begin
                if (issue)    n_q         <= n_q + 15'd1;
                if (final_hs) last_sent_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            len_q    <= secretkey_length;
            region_q <= key_addr_index;
        end
        if (state_q == ST_CHECK) begin
            words_q <= words_full[14:0];
            rem_q   <= len_q[5:0];
        end
    end

    // Read pipeline: valid and last-word flag travel with each issued read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
        end
        last_p0 <= last_issue;
        last_p1 <= last_p0;
    end

    assign push_vld  = (RD_LATENCY == 1) ? vld_p0  : vld_p1;
    assign push_last = (RD_LATENCY == 1) ? last_p0 : last_p1;
    assign fifo_din  = {push_last,
                        bram_douta & (push_last ? tail_mask(rem_q) : {KEY_WORD_W{1'b1}})};

    // Output stage: skid FIFO feeding the stream master
    pa_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_WORD_W + 1),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_vld),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_pop = !fifo_empty && m_tready;

`ifdef PA_KEY_CRC_EN
    logic [31:0] crc_q;
    logic        crc_pend_q;

    function automatic logic [31:0] crc32_word(input logic [31:0] c,
                                               input logic [KEY_WORD_W-1:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            r = r ^ {24'd0, w[b*8 +: 8]};
            for (int k = 0; k < 8; k++) begin
                r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_pend_q <= 1'b0;
        end else if (fifo_pop && fifo_head[KEY_WORD_W]) begin
            crc_pend_q <= 1'b1;
        end else if (final_hs) begin
            crc_pend_q <= 1'b0;
        end
        if (state_q == ST_CHECK) begin
            crc_q <= '1;
        end else if (fifo_pop) begin
            crc_q <= crc32_word(crc_q, fifo_head[KEY_WORD_W-1:0]);
        end
    end

    assign m_tvalid = !fifo_empty || crc_pend_q;
    assign m_tdata  = !fifo_empty ? fifo_head[KEY_WORD_W-1:0]
                    : (crc_pend_q ? {32'd0, ~crc_q} : '0);
    assign m_tlast  = fifo_empty && crc_pend_q;
    assign final_hs = fifo_empty && crc_pend_q && m_tready;
`else
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_empty ? '0 : fifo_head[KEY_WORD_W-1:0];
    assign m_tlast  = !fifo_empty && fifo_head[KEY_WORD_W];
    assign final_hs = fifo_pop && fifo_head[KEY_WORD_W];
`endif

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: begin
                err     = len_bad;
                state_d = len_bad ? ST_IDLE : ST_READ;
            end
            ST_READ:  if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && last_sent_q) state_d = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

endmodule
